// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 4-bit LFSR word stream
module lfsr_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       in_word,
  output logic             locked,
  output logic [3:0]       expected,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_W = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state, state_n;
  logic [3:0] match_cnt, match_n, miss_cnt, miss_n, expected_n, match_inc, miss_inc;
  logic locked_n, err_n, loss_n;
  logic [CNT_W-1:0] count_n;
  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;
  always_comb begin
    state_n    = state;
    expected_n = expected;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    locked_n   = locked;
    count_n    = err_count;
    err_n      = 1'b0;
    loss_n     = 1'b0;
    if (in_valid) begin
      case (state)
        SEARCH: if (in_word != 4'd0) begin
          state_n    = VERIFY;
          expected_n = nxt(in_word);
          match_n    = 4'd0;
        end
        VERIFY: if (in_word == expected) begin
          match_n    = match_inc;
          expected_n = nxt(in_word);
          if (match_inc == LOCK_W) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            miss_n   = 4'd0;
          end
        end else if (in_word == 4'd0) begin
          state_n    = SEARCH;
          expected_n = 4'd0;
        end else begin
          expected_n = nxt(in_word);
          match_n    = 4'd0;
        end
        LOCKED: begin
          // prediction free-runs so one bad word cannot derail it
          expected_n = nxt(expected);
          if (in_word == expected) miss_n = 4'd0;
          else begin
            err_n   = 1'b1;
            count_n = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);
            miss_n  = miss_inc;
            if (miss_inc == LOSS_W) begin
              state_n    = SEARCH;
              locked_n   = 1'b0;
              loss_n     = 1'b1;
              expected_n = 4'd0;
              miss_n     = 4'd0;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SEARCH;
      expected  <= 4'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= locked_n;
      err_pulse <= err_n;
      sync_loss <= loss_n;
      err_count <= count_n;
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed checks of lfsr_checker (8-bit and 2-bit counters) against a sequence-table model
module tb_lfsr_checker;
  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  logic clk = 0, rst = 0, in_valid = 0;
  logic [3:0] in_word = 0;
  logic locked_a, err_a, loss_a, locked_b, err_b, loss_b;
  logic [3:0] exp_a, exp_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  int errors = 0, checks = 0;
  logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                           4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
  int m_mode, m_pos, m_run, m_miss, m_err, m_locked, m_pulse, m_loss;
  bit armed = 0;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .locked(locked_a),
    .expected(exp_a), .err_pulse(err_a), .sync_loss(loss_a), .err_count(cnt_a));
  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .locked(locked_b),
    .expected(exp_b), .err_pulse(err_b), .sync_loss(loss_b), .err_count(cnt_b));

  always #5 clk = ~clk;

  function automatic int idx(input logic [3:0] w);
    for (int i = 0; i < 15; i++) if (seq[i] == w) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask

  // model: mode 0 search, 1 verify, 2 locked; m_pos indexes the predicted word in seq
  always @(posedge clk) begin
    if (!rst) begin
      m_mode = 0; m_pos = -1; m_run = 0; m_miss = 0; m_err = 0;
      m_locked = 0; m_pulse = 0; m_loss = 0; armed = 1;
    end else begin
      m_pulse = 0; m_loss = 0;
      if (in_valid) begin
        if (m_mode == 0) begin
          if (in_word != 0) begin m_mode = 1; m_pos = (idx(in_word) + 1) % 15; m_run = 0; end
        end else if (m_mode == 1) begin
          if (in_word == seq[m_pos]) begin
            m_run++; m_pos = (m_pos + 1) % 15;
            if (m_run == LOCK_CNT) begin m_mode = 2; m_locked = 1; m_miss = 0; end
          end else if (in_word == 0) begin
            m_mode = 0; m_pos = -1;
          end else begin
            m_pos = (idx(in_word) + 1) % 15; m_run = 0;
          end
        end else begin
          if (in_word == seq[m_pos]) m_miss = 0;
          else begin m_pulse = 1; m_err++; m_miss++; end
          m_pos = (m_pos + 1) % 15;
          if (m_miss == LOSS_CNT) begin
            m_mode = 0; m_locked = 0; m_loss = 1; m_pos = -1; m_miss = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("locked_a", locked_a, m_locked);
    chk("locked_b", locked_b, m_locked);
    chk("expected_a", exp_a, m_pos < 0 ? 0 : seq[m_pos]);
    chk("expected_b", exp_b, m_pos < 0 ? 0 : seq[m_pos]);
    chk("err_pulse_a", err_a, m_pulse);
    chk("err_pulse_b", err_b, m_pulse);
    chk("sync_loss_a", loss_a, m_loss);
    chk("sync_loss_b", loss_b, m_loss);
    chk("err_count_a", cnt_a, m_err > 255 ? 255 : m_err);
    chk("err_count_b", cnt_b, m_err > 3 ? 3 : m_err);
  end

  task automatic drive(input logic r, input logic v, input logic [3:0] w);
    rst = r; in_valid = v; in_word = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] w;
    int p;
    drive(0, 0, 4'h0);
    drive(0, 1, 4'hF);
    chk("rst_locked", locked_a, 0);
    chk("rst_expected", exp_a, 0);
    chk("rst_count", cnt_a, 0);
    drive(1, 1, 4'hF);
    chk("seed_expected", exp_a, 4'hE);
    drive(1, 1, 4'hE);
    drive(1, 1, 4'hC);
    chk("pre_lock", locked_a, 0);
    drive(1, 1, 4'h8);
    chk("lock_locked", locked_a, 1);
    chk("lock_expected", exp_a, 4'h1);
    chk("lock_count", cnt_a, 0);
    drive(1, 1, 4'h1);
    drive(1, 1, 4'h3);
    chk("single_pulse", err_a, 1);
    chk("single_count", cnt_a, 1);
    chk("single_locked", locked_a, 1);
    chk("single_expected", exp_a, 4'h4);
    drive(1, 1, 4'h4);
    chk("recover_pulse", err_a, 0);
    drive(1, 1, 4'h9);
    drive(1, 1, 4'h0);
    chk("miss1_loss", loss_a, 0);
    chk("miss1_locked", locked_a, 1);
    drive(1, 1, 4'h0);
    chk("miss2_loss", loss_a, 1);
    chk("miss2_pulse", err_a, 1);
    chk("miss2_locked", locked_a, 0);
    chk("miss2_count", cnt_a, 3);
    chk("miss2_expected", exp_a, 0);
    drive(1, 0, 4'h6);
    chk("loss_clear", loss_a, 0);
    drive(1, 1, 4'hD);
    drive(1, 1, 4'hA);
    drive(1, 1, 4'h5);
    drive(1, 1, 4'hB);
    chk("relock", locked_a, 1);
    chk("relock_expected", exp_a, 4'h7);
    drive(1, 0, 4'h3);
    drive(1, 0, 4'h0);
    chk("gap_expected", exp_a, 4'h7);
    chk("gap_locked", locked_a, 1);
    foreach (seq[i]) if (i < 10) drive(1, 1, (i % 2 == 0) ? 4'h0 : seq[(i + 14) % 15]);
    chk("sat_count_a", cnt_a, 8);
    chk("sat_count_b", cnt_b, 3);
    chk("sat_locked", locked_a, 1);
    drive(0, 1, 4'h5);
    chk("midrst_locked", locked_a, 0);
    chk("midrst_count", cnt_a, 0);
    chk("midrst_expected", exp_a, 0);
    drive(1, 1, 4'h0);
    chk("zero_search", exp_a, 0);
    drive(1, 1, 4'hF);
    drive(1, 0, 4'h9);
    chk("verify_gap", exp_a, 4'hE);
    drive(1, 1, 4'h5);
    chk("reseed_expected", exp_a, 4'hB);
    chk("reseed_count", cnt_a, 0);
    drive(1, 1, 4'hB);
    drive(1, 1, 4'h7);
    chk("reseed_nolock", locked_a, 0);
    drive(1, 1, 4'hF);
    chk("reseed_lock", locked_a, 1);
    drive(1, 1, 4'h0);
    drive(1, 1, 4'h3);
    chk("loss_any_word", loss_a, 1);
    p = 0;
    for (int k = 0; k < 120; k++) begin
      w = seq[p % 15];
      if ($urandom_range(0, 7) == 0) w = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) begin drive(1, 1, w); p++; end
      else drive(1, 0, 4'($urandom_range(0, 15)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
